// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder.
// Error bit positions and FSM state encodings.
package dmem_resp_pkg;
  localparam int DMEM_ERR_TIMEOUT = 0;
  localparam int DMEM_ERR_OVERRUN = 1;
  localparam int DMEM_ERR_WIDTH   = 2;

  typedef enum logic {
    DMEM_STATE_IDLE   = 1'b0,
    DMEM_STATE_ACCESS = 1'b1
  } dmem_state_e;
endpackage

// File: rtl/dmem_resp_if.sv
// Variable-latency data-memory bus with req/ack handshake.
// master = responder side, slave = memory side.
interface dmem_resp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_timeout_cnt.sv
// Saturating request-cycle counter; tc marks the last
// request cycle allowed before the access is aborted.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && cnt_q != MAX)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // cnt_q counts completed request cycles
  assign tc = (cnt_q >= LAST);
endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: turns the controller access strobe
// into a held req/ack transaction with sticky error flags.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dmem_update,
  input  logic                      dmem_write,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      rdata_valid,
  output logic                      busy,
  output logic [DMEM_ERR_WIDTH-1:0] err,
  input  logic                      err_clr,
  dmem_resp_if.master               mem
);
  dmem_state_e state_q, state_d;

  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic [DMEM_ERR_WIDTH-1:0] err_q, err_d;
  logic                      cnt_clr, cnt_en, tc;

  dmem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .enable(cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    // new error events are applied after the clear
    err_d   = err_clr ? '0 : err_q;
    if (dmem_update && busy_q)
      err_d[DMEM_ERR_OVERRUN] = 1'b1;
    unique case (state_q)
      DMEM_STATE_IDLE: begin
        if (dmem_update) begin
          state_d = DMEM_STATE_ACCESS;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          we_d    = dmem_write;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_clr = 1'b1;
        end
      end
      DMEM_STATE_ACCESS: begin
        cnt_en = 1'b1;
        if (mem.mem_ack) begin
          if (!we_q) begin
            rdata_d = mem.mem_rdata;
            valid_d = 1'b1;
          end
          state_d = DMEM_STATE_IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          we_d    = 1'b0;
        end else if (tc) begin
          state_d = DMEM_STATE_IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          we_d    = 1'b0;
          err_d[DMEM_ERR_TIMEOUT] = 1'b1;
        end
      end
      default: state_d = DMEM_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMEM_STATE_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign rdata         = rdata_q;
  assign rdata_valid   = valid_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_dmem_resp;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_upd = 1'b0;
  logic          in_wr = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_wdata = '0;
  logic          in_clr = 1'b0;
  logic          in_ack = 1'b0;
  logic [DW-1:0] in_rd = '0;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          busy;
  logic [1:0]    err;

  int n_vec = 0;
  int n_err = 0;

  dmem_resp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  assign mif.mem_ack   = in_ack;
  assign mif.mem_rdata = in_rd;

  dmem_resp #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_update(in_upd),
    .dmem_write (in_wr),
    .addr       (in_addr),
    .wdata      (in_wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .busy       (busy),
    .err        (err),
    .err_clr    (in_clr),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  // reference model: one outstanding access, counted in cycles
  bit            m_access;
  int            m_n;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_valid;
  logic [1:0]    m_err;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_access = 0;
    m_n      = 0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_rdata  = '0;
    m_valid  = 1'b0;
    m_err    = '0;
  endtask

  task automatic model_step();
    logic [1:0] nerr;
    nerr    = in_clr ? 2'b00 : m_err;
    m_valid = 1'b0;
    if (m_access) begin
      if (in_upd) nerr[1] = 1'b1;
      m_n++;
      if (in_ack) begin
        if (!m_we) begin
          m_rdata = in_rd;
          m_valid = 1'b1;
        end
        m_access = 0;
      end else if (m_n == TO) begin
        nerr[0]  = 1'b1;
        m_access = 0;
      end
    end else if (in_upd) begin
      m_access = 1;
      m_n      = 0;
      m_we     = in_wr;
      m_addr   = in_addr;
      m_wdata  = in_wdata;
    end
    m_err = nerr;
  endtask

  task automatic check_all();
    chk("mem_req", mif.mem_req, m_access);
    chk("busy", busy, m_access);
    chk("mem_we", mif.mem_we, m_access & m_we);
    chk("mem_addr", mif.mem_addr, m_addr);
    chk("mem_wdata", mif.mem_wdata, m_wdata);
    chk("rdata", rdata, m_rdata);
    chk("rdata_valid", rdata_valid, m_valid);
    chk("err", err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic start(logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    in_upd   = 1'b1;
    in_wr    = wr;
    in_addr  = a;
    in_wdata = d;
    tick();
    in_upd = 1'b0;
  endtask

  int reqcnt;
  int ackp;

  initial begin
    model_reset();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // read, ack after three wait cycles
    start(1'b0, 8'h2A, 16'h0);
    chk("rd_addr", mif.mem_addr, 8'h2A);
    repeat (3) tick();
    chk("rd_req_c4", mif.mem_req, 1'b1);
    in_ack = 1'b1;
    in_rd  = 16'hBEEF;
    tick();
    in_ack = 1'b0;
    chk("rd_data", rdata, 16'hBEEF);
    chk("rd_pulse", rdata_valid, 1'b1);
    chk("rd_busy", busy, 1'b0);
    tick();
    chk("rd_pulse_end", rdata_valid, 1'b0);

    // write, immediate ack
    start(1'b1, 8'h10, 16'h1234);
    chk("wr_we", mif.mem_we, 1'b1);
    chk("wr_wdata", mif.mem_wdata, 16'h1234);
    in_ack = 1'b1;
    in_rd  = 16'h5555;
    tick();
    in_ack = 1'b0;
    chk("wr_we_drop", mif.mem_we, 1'b0);
    chk("wr_no_pulse", rdata_valid, 1'b0);
    chk("wr_rdata_kept", rdata, 16'hBEEF);

    // timeout
    start(1'b0, 8'h01, 16'h0);
    reqcnt = mif.mem_req ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mif.mem_req) reqcnt++;
    end
    chk("to_len", reqcnt, TO);
    chk("to_err", err, 2'b01);
    in_clr = 1'b1;
    tick();
    in_clr = 1'b0;
    chk("to_clr", err, 2'b00);

    // ack on terminal count
    start(1'b0, 8'h02, 16'h0);
    repeat (TO - 1) tick();
    in_ack = 1'b1;
    in_rd  = 16'hCAFE;
    tick();
    in_ack = 1'b0;
    chk("tc_err", err, 2'b00);
    chk("tc_pulse", rdata_valid, 1'b1);
    chk("tc_data", rdata, 16'hCAFE);

    // overrun
    start(1'b0, 8'h33, 16'h0);
    in_upd  = 1'b1;
    in_addr = 8'h55;
    tick();
    in_upd = 1'b0;
    chk("ov_addr", mif.mem_addr, 8'h33);
    tick();
    in_ack = 1'b1;
    in_rd  = 16'h0A0A;
    tick();
    in_ack = 1'b0;
    chk("ov_err", err, 2'b10);
    tick();
    chk("ov_never", mif.mem_req, 1'b0);
    in_clr = 1'b1;
    tick();
    in_clr = 1'b0;

    // stray ack while idle
    in_ack = 1'b1;
    in_rd  = 16'hDEAD;
    tick();
    in_ack = 1'b0;
    chk("idle_ack", rdata, 16'h0A0A);

    // reset mid-access
    start(1'b0, 8'h44, 16'h0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_req", mif.mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", rdata_valid, 1'b0);
    model_reset();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    start(1'b0, 8'h66, 16'h0);
    tick();
    in_ack = 1'b1;
    in_rd  = 16'h7777;
    tick();
    in_ack = 1'b0;
    chk("post_rst_data", rdata, 16'h7777);

    // random traffic, alternating ack density
    for (int blk = 0; blk < 6; blk++) begin
      ackp = (blk % 2 == 0) ? 3 : 14;
      for (int i = 0; i < 500; i++) begin
        in_upd   = ($urandom_range(3) == 0);
        in_wr    = 1'($urandom_range(1));
        in_addr  = AW'($urandom);
        in_wdata = DW'($urandom);
        in_clr   = ($urandom_range(19) == 0);
        in_ack   = ($urandom_range(ackp - 1) == 0);
        in_rd    = DW'($urandom);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Data-memory responder that sits between the MCU/datapath and the data memory bus. It accepts the controller's dmem_update/dmem_write access strobe and converts it into a held request on a variable-latency memory port with an ack handshake. It returns read data with a valid pulse, exposes a busy/stall indication to the controller, and records sticky timeout/overrun errors.

Parameters:
DATA_WIDTH, 16, width of data words on both sides.
ADDR_WIDTH, 8, width of data-memory address.
TIMEOUT, 15, maximum mem_req cycles without mem_ack before abort (1..255).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
dmem_update  in  1  access strobe from controller, sampled each cycle.
dmem_write  in  1  1 = write, 0 = read; qualified by dmem_update.
addr  in  ADDR_WIDTH  access address; qualified by dmem_update.
wdata  in  DATA_WIDTH  write data; qualified by dmem_update.
rdata  out  DATA_WIDTH  last read data; held until the next read completes.
rdata_valid  out  1  one-cycle pulse when rdata updates.
busy  out  1  access in progress; controller stall.
err  out  2  sticky errors: bit0 = timeout, bit1 = overrun.
err_clr  in  1  synchronous clear of err.
mem_req  out  1  memory request, held until ack or timeout.
mem_we  out  1  memory write enable, valid with mem_req.
mem_addr  out  ADDR_WIDTH  latched address.
mem_wdata  out  DATA_WIDTH  latched write data.
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
mem_ack  in  1  memory completion, one cycle, sampled only while mem_req = 1.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State = IDLE.
  - rdata, mem_addr, mem_wdata = 0.
  - rdata_valid, busy, mem_req, mem_we = 0; err = 0.
  - mem_req drops immediately even mid-access; no completion or error is reported for the aborted access.
- States are IDLE and ACCESS. All outputs are registered.
- IDLE:
  - dmem_update = 1 latches addr/wdata/dmem_write into mem_addr/mem_wdata/mem_we.
  - Clears the timeout counter and moves to ACCESS; mem_req = 1 and busy = 1 from the next cycle.
  - Accept-to-request latency is 1 cycle.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable; the counter increments each cycle.
  - mem_ack = 1, read: rdata <= mem_rdata and rdata_valid = 1 the next cycle.
  - mem_ack = 1, write: no rdata change and no pulse.
  - On any ack: mem_req, busy and mem_we = 0 next cycle; return to IDLE.
  - Counter reaches TIMEOUT with no ack: mem_req and busy = 0 next cycle, err[0] set, rdata unchanged, no valid pulse, return to IDLE.
  - Ack on the same cycle as terminal count: ack wins and no timeout is flagged.
- Overrun:
  - dmem_update = 1 while busy = 1 is dropped and sets err[1].
  - The in-flight access is unaffected.
  - An update arriving in the cycle ACCESS exits is also dropped, because busy is still 1.
  - Back-to-back throughput is therefore one access per (ack latency + 2) cycles.
- Error clear:
  - err_clr clears err next cycle.
  - A simultaneous new error event wins over err_clr (the bit stays set).
- mem_ack while mem_req = 0 is ignored.
- The counter is wide enough for TIMEOUT and saturates; it never wraps.

Decomposition:
- Shared defs: DMEM_ERR_TIMEOUT = 0, DMEM_ERR_OVERRUN = 1, DMEM_ERR_WIDTH = 2, and the state encodings DMEM_STATE_IDLE/ACCESS.
- Sub-module dmem_timeout_cnt:
  - Inputs: clear, enable.
  - Output: terminal-count flag.
  - Parameterized by TIMEOUT.
  - Same clk/rst convention.
- Everything else lives in dmem_resp.

Test Plan:
- Read, ack after 3 cycles:
  - Stimulus: dmem_update = 1, dmem_write = 0, addr = 0x2A; memory returns 0xBEEF.
  - Response: mem_req high cycles 1-4 with mem_addr = 0x2A, mem_we = 0; rdata = 0xBEEF with a single rdata_valid pulse at cycle 5; busy low at cycle 5.
- Write, immediate ack:
  - Stimulus: dmem_write = 1, addr = 0x10, wdata = 0x1234; mem_ack in the first mem_req cycle.
  - Response: mem_we = 1, mem_wdata = 0x1234 for exactly 1 cycle; no rdata_valid; rdata unchanged.
- Timeout:
  - Stimulus: TIMEOUT = 15, read, mem_ack never asserted.
  - Response: mem_req high exactly 15 cycles, then low; err = 2'b01; no valid pulse.
  - Follow-up: err_clr pulse returns err to 0.
- Ack on terminal count:
  - Stimulus: mem_ack on the 15th request cycle.
  - Response: read completes normally; err stays 0.
- Overrun:
  - Stimulus: second dmem_update (addr = 0x55) while busy.
  - Response: err = 2'b10; the first access completes with its original mem_addr; 0x55 is never issued.
- Reset mid-access:
  - Stimulus: rst low while mem_req = 1, between clock edges.
  - Response: mem_req/busy/rdata_valid drop immediately; after release, state is IDLE and a new read works normally.
